// File: rtl/ibuffer_credit.sv
// Per-warp credit-managed instruction buffer between fetch/decode and issue.
// Optional protocol checker with sticky Err_IB is enabled by defining IB_ERRCHK_EN.
module ibuffer_credit #(
    parameter int unsigned NUM_WARPS = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CTRL_W    = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [NUM_WARPS-1:0] Req_IB_PC,
    input  logic [NUM_WARPS-1:0] Valid_IF_IB,
    input  logic [NUM_WARPS-1:0] Valid_ID0_IB_SIMT,
    input  logic [31:0]          Inst_ID0_IB,
    input  logic [CTRL_W-1:0]    Ctrl_ID0_IB,
    input  logic [NUM_WARPS-1:0] Valid_ID1_IB_SIMT,
    input  logic [31:0]          Inst_ID1_IB,
    input  logic [CTRL_W-1:0]    Ctrl_ID1_IB,
    input  logic [NUM_WARPS-1:0] Flush_SIMT_IB,
    output logic [NUM_WARPS-1:0] Ready_IB_ISS,
    input  logic [NUM_WARPS-1:0] Grant_ISS_IB,
    output logic [31:0]          Inst_IB_ISS,
    output logic [CTRL_W-1:0]    Ctrl_IB_ISS
`ifdef IB_ERRCHK_EN
    ,
    output logic                 Err_IB
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = 32 + CTRL_W;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW:0]   FULL_X = (CW + 1)'(DEPTH);

    logic [CW-1:0] occ_q  [NUM_WARPS];
    logic [CW-1:0] occ_d  [NUM_WARPS];
    logic [CW-1:0] out_q  [NUM_WARPS];
    logic [CW-1:0] out_d  [NUM_WARPS];
    logic [CW-1:0] drop_q [NUM_WARPS];
    logic [CW-1:0] drop_d [NUM_WARPS];
    logic [PW-1:0] rd_q   [NUM_WARPS];
    logic [PW-1:0] rd_d   [NUM_WARPS];
    logic [PW-1:0] wr_q   [NUM_WARPS];
    logic [PW-1:0] wr_d   [NUM_WARPS];

    logic [1:0]    we [NUM_WARPS];
    logic [PW-1:0] wa [NUM_WARPS][2];
    logic [EW-1:0] lane_data [2];
    logic [EW-1:0] mem [NUM_WARPS][DEPTH];
    logic [EW-1:0] head_mux;

`ifdef IB_ERRCHK_EN
    logic viol;

    function automatic logic multi_hot(input logic [NUM_WARPS-1:0] v);
        return |(v & (v - NUM_WARPS'(1)));
    endfunction
`endif

    always_comb begin
        lane_data[0] = {Inst_ID0_IB, Ctrl_ID0_IB};
        lane_data[1] = {Inst_ID1_IB, Ctrl_ID1_IB};
    end

    // Per warp: pop first, then lane 0, then lane 1, so a full FIFO accepts a push alongside a pop.
    always_comb begin : next_state
        logic [CW-1:0] occ_t;
        logic [CW-1:0] out_t;
        logic [CW-1:0] drop_t;
        logic [PW-1:0] wr_t;
        logic [PW-1:0] rd_t;
        logic [1:0]    arr;
        occ_t  = '0;
        out_t  = '0;
        drop_t = '0;
        wr_t   = '0;
        rd_t   = '0;
        arr    = '0;
`ifdef IB_ERRCHK_EN
        viol = multi_hot(Valid_IF_IB) | multi_hot(Valid_ID0_IB_SIMT) |
               multi_hot(Valid_ID1_IB_SIMT) | multi_hot(Grant_ISS_IB);
`endif
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            occ_t    = occ_q[w];
            out_t    = out_q[w];
            drop_t   = drop_q[w];
            wr_t     = wr_q[w];
            rd_t     = rd_q[w];
            arr      = {Valid_ID1_IB_SIMT[w], Valid_ID0_IB_SIMT[w]};
            we[w]    = '0;
            wa[w][0] = wr_q[w];
            wa[w][1] = wr_q[w];

            if (Grant_ISS_IB[w]) begin
                if (occ_q[w] == '0) begin
`ifdef IB_ERRCHK_EN
                    viol = 1'b1;
`endif
                end else if (!Flush_SIMT_IB[w]) begin
                    occ_t = occ_t - CW'(1);
                    rd_t  = rd_t + PW'(1);
                end
            end

            for (int unsigned l = 0; l < 2; l++) begin
                if (arr[l]) begin
                    if (out_t == '0) begin
`ifdef IB_ERRCHK_EN
                        viol = 1'b1;
`endif
                    end else begin
                        out_t = out_t - CW'(1);
                    end
                    if (!Flush_SIMT_IB[w]) begin
                        if (drop_t != '0) begin
                            drop_t = drop_t - CW'(1);
                        end else if (occ_t == FULL) begin
`ifdef IB_ERRCHK_EN
                            viol = 1'b1;
`endif
                        end else begin
                            we[w][l] = 1'b1;
                            wa[w][l] = wr_t;
                            wr_t     = wr_t + PW'(1);
                            occ_t    = occ_t + CW'(1);
                        end
                    end
                end
            end

            if (Valid_IF_IB[w] && out_t != FULL) begin
                out_t = out_t + CW'(1);
            end

            // Everything still in flight after this edge belongs to the flushed path.
            if (Flush_SIMT_IB[w]) begin
                occ_t  = '0;
                rd_t   = wr_q[w];
                drop_t = out_t;
            end

            occ_d[w]  = occ_t;
            out_d[w]  = out_t;
            drop_d[w] = drop_t;
            wr_d[w]   = wr_t;
            rd_d[w]   = rd_t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                occ_q[w]  <= '0;
                out_q[w]  <= '0;
                drop_q[w] <= '0;
                rd_q[w]   <= '0;
                wr_q[w]   <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                occ_q[w]  <= occ_d[w];
                out_q[w]  <= out_d[w];
                drop_q[w] <= drop_d[w];
                rd_q[w]   <= rd_d[w];
                wr_q[w]   <= wr_d[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            for (int unsigned l = 0; l < 2; l++) begin
                if (we[w][l]) begin
                    mem[w][wa[w][l]] <= lane_data[l];
                end
            end
        end
    end

`ifdef IB_ERRCHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Err_IB <= 1'b0;
        end else if (viol) begin
            Err_IB <= 1'b1;
        end
    end
`endif

    always_comb begin
        head_mux = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            Req_IB_PC[w]    = (({1'b0, occ_q[w]} + {1'b0, out_q[w]}) < FULL_X) &&
                              (drop_q[w] == '0) && !Flush_SIMT_IB[w];
            Ready_IB_ISS[w] = (occ_q[w] != '0);
            if (Grant_ISS_IB[w] && occ_q[w] != '0) begin
                head_mux = head_mux | mem[w][rd_q[w]];
            end
        end
        Inst_IB_ISS = head_mux[EW-1:CTRL_W];
        Ctrl_IB_ISS = head_mux[CTRL_W-1:0];
    end

endmodule

// File: tb/tb_ibuffer_credit.sv
// Scoreboard bench for ibuffer_credit: per-warp expected queues filled on decode, drained on grant.
module tb_ibuffer_credit;

    localparam int NW = 8;
    localparam int CW = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NW-1:0] Req_IB_PC;
    logic [NW-1:0] Valid_IF_IB;
    logic [NW-1:0] Valid_ID0_IB_SIMT;
    logic [31:0]   Inst_ID0_IB;
    logic [CW-1:0] Ctrl_ID0_IB;
    logic [NW-1:0] Valid_ID1_IB_SIMT;
    logic [31:0]   Inst_ID1_IB;
    logic [CW-1:0] Ctrl_ID1_IB;
    logic [NW-1:0] Flush_SIMT_IB;
    logic [NW-1:0] Ready_IB_ISS;
    logic [NW-1:0] Grant_ISS_IB;
    logic [31:0]   Inst_IB_ISS;
    logic [CW-1:0] Ctrl_IB_ISS;
`ifdef IB_ERRCHK_EN
    logic          Err_IB;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [79:0] sb [NW][$];

    always #5 clk = ~clk;

    ibuffer_credit #(.NUM_WARPS(NW), .DEPTH(4), .CTRL_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Req_IB_PC(Req_IB_PC),
        .Valid_IF_IB(Valid_IF_IB),
        .Valid_ID0_IB_SIMT(Valid_ID0_IB_SIMT),
        .Inst_ID0_IB(Inst_ID0_IB),
        .Ctrl_ID0_IB(Ctrl_ID0_IB),
        .Valid_ID1_IB_SIMT(Valid_ID1_IB_SIMT),
        .Inst_ID1_IB(Inst_ID1_IB),
        .Ctrl_ID1_IB(Ctrl_ID1_IB),
        .Flush_SIMT_IB(Flush_SIMT_IB),
        .Ready_IB_ISS(Ready_IB_ISS),
        .Grant_ISS_IB(Grant_ISS_IB),
        .Inst_IB_ISS(Inst_IB_ISS),
        .Ctrl_IB_ISS(Ctrl_IB_ISS)
`ifdef IB_ERRCHK_EN
        ,
        .Err_IB(Err_IB)
`endif
    );

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk_ctrl(input logic [31:0] inst);
        return {inst[15:0] ^ 16'hA5A5, ~inst};
    endfunction

    function automatic logic [NW-1:0] bit_of(input int w);
        return NW'(1) << w;
    endfunction

    task automatic clear_in();
        Valid_IF_IB       = '0;
        Valid_ID0_IB_SIMT = '0;
        Inst_ID0_IB       = '0;
        Ctrl_ID0_IB       = '0;
        Valid_ID1_IB_SIMT = '0;
        Inst_ID1_IB       = '0;
        Ctrl_ID1_IB       = '0;
        Flush_SIMT_IB     = '0;
        Grant_ISS_IB      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
        #1;
    endtask

    task automatic fetch(input int w);
        Valid_IF_IB = bit_of(w);
        #1;
        check_eq("req_before_fetch", 80'(Req_IB_PC[w]), 80'd1);
        tick();
    endtask

    task automatic decode0(input int w, input logic [31:0] inst, input bit keep);
        Valid_ID0_IB_SIMT = bit_of(w);
        Inst_ID0_IB       = inst;
        Ctrl_ID0_IB       = mk_ctrl(inst);
        if (keep) sb[w].push_back({inst, mk_ctrl(inst)});
        tick();
    endtask

    task automatic grant(input int w);
        logic [79:0] exp;
        exp = '0;
        if (sb[w].size() > 0) exp = sb[w].pop_front();
        Grant_ISS_IB = bit_of(w);
        #1;
        check_eq("issue_head", {Inst_IB_ISS, Ctrl_IB_ISS}, exp);
        tick();
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int w = 0; w < NW; w++) sb[w].delete();
    endtask

    initial begin
        logic [79:0] exp;
        do_reset();
        repeat (3) tick();
        check_eq("reset_req", 80'(Req_IB_PC), 80'hFF);
        check_eq("reset_ready", 80'(Ready_IB_ISS), 80'h0);
        check_eq("reset_out", {Inst_IB_ISS, Ctrl_IB_ISS}, 80'h0);

        // Warp 2: exhaust credits, then fill, then drain
        for (int i = 0; i < 4; i++) fetch(2);
        check_eq("w2_req_no_credit", 80'(Req_IB_PC[2]), 80'd0);
        for (int i = 0; i < 4; i++) begin
            decode0(2, 32'h200 + i, 1'b1);
            check_eq("w2_ready", 80'(Ready_IB_ISS[2]), 80'd1);
            check_eq("w2_req_held", 80'(Req_IB_PC[2]), 80'd0);
        end
        check_eq("w2_no_grant_zero", {Inst_IB_ISS, Ctrl_IB_ISS}, 80'h0);
        grant(2);
        check_eq("w2_req_after_pop", 80'(Req_IB_PC[2]), 80'd1);
        for (int i = 0; i < 3; i++) grant(2);
        check_eq("w2_empty", 80'(Ready_IB_ISS[2]), 80'd0);

        // Warp 5: dual-lane arrival, ID0 ordered before ID1
        fetch(5);
        fetch(5);
        Valid_ID0_IB_SIMT = bit_of(5);
        Inst_ID0_IB       = 32'hA;
        Ctrl_ID0_IB       = mk_ctrl(32'hA);
        Valid_ID1_IB_SIMT = bit_of(5);
        Inst_ID1_IB       = 32'hB;
        Ctrl_ID1_IB       = mk_ctrl(32'hB);
        sb[5].push_back({32'hA, mk_ctrl(32'hA)});
        sb[5].push_back({32'hB, mk_ctrl(32'hB)});
        tick();
        check_eq("w5_ready", 80'(Ready_IB_ISS[5]), 80'd1);
        grant(5);
        check_eq("w5_ready_one_left", 80'(Ready_IB_ISS[5]), 80'd1);
        grant(5);
        check_eq("w5_empty", 80'(Ready_IB_ISS[5]), 80'd0);

        // Warp 1: flush with two stored and two in flight
        for (int i = 0; i < 4; i++) fetch(1);
        decode0(1, 32'h10, 1'b1);
        decode0(1, 32'h11, 1'b1);
        Flush_SIMT_IB = bit_of(1);
        Grant_ISS_IB  = bit_of(1);
        #1;
        check_eq("w1_req_during_flush", 80'(Req_IB_PC[1]), 80'd0);
        check_eq("w1_flush_grant_head", {Inst_IB_ISS, Ctrl_IB_ISS}, sb[1][0]);
        tick();
        sb[1].delete();
        check_eq("w1_ready_after_flush", 80'(Ready_IB_ISS[1]), 80'd0);
        check_eq("w1_req_after_flush", 80'(Req_IB_PC[1]), 80'd0);
        decode0(1, 32'h1E, 1'b0);
        check_eq("w1_req_draining", 80'(Req_IB_PC[1]), 80'd0);
        check_eq("w1_dropped_not_ready", 80'(Ready_IB_ISS[1]), 80'd0);
        decode0(1, 32'h1F, 1'b0);
        check_eq("w1_req_drained", 80'(Req_IB_PC[1]), 80'd1);
        check_eq("w1_still_empty", 80'(Ready_IB_ISS[1]), 80'd0);
        fetch(1);
        decode0(1, 32'h1C, 1'b1);
        check_eq("w1_new_ready", 80'(Ready_IB_ISS[1]), 80'd1);
        grant(1);
        check_eq("w1_empty", 80'(Ready_IB_ISS[1]), 80'd0);

        // Warp 3: full FIFO with simultaneous push and pop, wrapping pointers
        for (int i = 0; i < 4; i++) fetch(3);
        for (int i = 0; i < 4; i++) decode0(3, 32'h30 + i, 1'b1);
        for (int i = 0; i < 6; i++) begin
            exp = sb[3].pop_front();
            Grant_ISS_IB      = bit_of(3);
            Valid_ID0_IB_SIMT = bit_of(3);
            Inst_ID0_IB       = 32'h34 + i;
            Ctrl_ID0_IB       = mk_ctrl(32'h34 + i);
            sb[3].push_back({32'h34 + i, mk_ctrl(32'h34 + i)});
            #1;
            check_eq("w3_pushpop_head", {Inst_IB_ISS, Ctrl_IB_ISS}, exp);
            tick();
            check_eq("w3_ready_full", 80'(Ready_IB_ISS[3]), 80'd1);
            check_eq("w3_req_full", 80'(Req_IB_PC[3]), 80'd0);
        end
        for (int i = 0; i < 4; i++) grant(3);
        check_eq("w3_empty", 80'(Ready_IB_ISS[3]), 80'd0);
        check_eq("w3_req_back", 80'(Req_IB_PC[3]), 80'd1);
`ifdef IB_ERRCHK_EN
        check_eq("err_after_zero_credit_push", 80'(Err_IB), 80'd1);
        do_reset();
        #1;
        check_eq("err_cleared_by_reset", 80'(Err_IB), 80'd0);
`endif

        // Grant to an empty warp
        Grant_ISS_IB = bit_of(7);
        #1;
        check_eq("w7_empty_grant_zero", {Inst_IB_ISS, Ctrl_IB_ISS}, 80'h0);
        tick();
        check_eq("w7_not_ready", 80'(Ready_IB_ISS[7]), 80'd0);
`ifdef IB_ERRCHK_EN
        check_eq("err_set", 80'(Err_IB), 80'd1);
        repeat (3) tick();
        check_eq("err_sticky", 80'(Err_IB), 80'd1);
`endif
        check_eq("final_req", 80'(Req_IB_PC), 80'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ibuffer_credit.md
Name: ibuffer_credit

Overview:
- Per-warp instruction buffer. Receiving end of the fetch/decode → IB interface.
- Generates the per-warp fetch request vector `Req_IB_PC` from occupancy plus in-flight credits.
- Accepts decoded instructions from decode lanes ID0 and ID1, stores them in 8 per-warp FIFOs, and presents FIFO heads to issue.
- Discards instructions of a warp on a control-flow flush.

Parameters:
- NUM_WARPS, 8, number of warps; all warp vectors are NUM_WARPS bits.
- DEPTH, 4, entries per warp FIFO (power of 2, ≥2).
- CTRL_W, 48, width of packed decoded control field (src/dst/valids/ALUop/mem/branch/exit bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Req_IB_PC  out  NUM_WARPS  per-warp fetch request; high when warp has a free credit and is not draining
- Valid_IF_IB  in  NUM_WARPS  one-hot (or zero): warp whose fetch was accepted this cycle
- Valid_ID0_IB_SIMT  in  NUM_WARPS  one-hot (or zero): warp of the lane-0 decoded instruction
- Inst_ID0_IB  in  32  lane-0 raw instruction
- Ctrl_ID0_IB  in  CTRL_W  lane-0 decoded control
- Valid_ID1_IB_SIMT  in  NUM_WARPS  one-hot (or zero): warp of the lane-1 decoded instruction
- Inst_ID1_IB  in  32  lane-1 raw instruction
- Ctrl_ID1_IB  in  CTRL_W  lane-1 decoded control
- Flush_SIMT_IB  in  NUM_WARPS  per-warp flush (taken branch / call / ret / jmp resolved)
- Ready_IB_ISS  out  NUM_WARPS  FIFO non-empty per warp
- Grant_ISS_IB  in  NUM_WARPS  one-hot (or zero): pop head of that warp this cycle
- Inst_IB_ISS  out  32  head instruction of granted warp; 0 when no grant
- Ctrl_IB_ISS  out  CTRL_W  head control of granted warp; 0 when no grant
- Err_IB  out  1  sticky protocol error (present only with IB_ERRCHK_EN)

Behaviour:
- Per-warp state registers:
  - occ (0..DEPTH)
  - out: fetches accepted but not yet decoded (0..DEPTH)
  - drop: in-flight instructions to discard after a flush (0..DEPTH)
  - rd_ptr and wr_ptr, log2(DEPTH) bits, wrapping modulo DEPTH
- Reset (async): all counters, pointers, `Err_IB` = 0. Hence `Req_IB_PC` = all ones, `Ready_IB_ISS` = 0, `Inst_IB_ISS`/`Ctrl_IB_ISS` = 0. FIFO storage is not reset.
- Request, combinational from registered state:
  - `Req_IB_PC[w]` = (occ+out < DEPTH) && (drop == 0) && !`Flush_SIMT_IB[w]`.
  - Fetch may accept a warp only while its Req is high.
  - The credit takes effect next edge (`out` increments), so a warp never exceeds DEPTH total.
- Decode arrival for warp w:
  - drop > 0: instruction is discarded; drop and out each decrement.
  - drop == 0: written at wr_ptr; wr_ptr+1, occ+1, out−1.
  - Both lanes targeting the same warp in one cycle: ID0 is written before ID1 (two slots, occ+2, out−2). The drop rule applies per lane in order ID0 then ID1.
- Issue:
  - `Ready_IB_ISS[w]` = occ != 0.
  - Grant to a ready warp: head is muxed combinationally onto `Inst_IB_ISS`/`Ctrl_IB_ISS`; rd_ptr+1 and occ−1 at the edge.
  - A push and a pop to the same warp in one cycle are both performed (occ unchanged for one push plus one pop).
- Flush of warp w (highest priority for that warp):
  - occ ← 0; rd_ptr ← wr_ptr.
  - drop ← out + (same-cycle Valid_IF_IB[w]) − (same-cycle non-dropped ID arrivals discounted; arrivals in the flush cycle are discarded).
  - Same-cycle grant to w is ignored: no pop, outputs still show the head, and issue must not consume it.
  - Req for w returns once drop reaches 0.
- Overflow or underflow cannot occur when neighbours obey the protocol.
- Behaviour when violated:
  - Push to a full FIFO: write ignored.
  - Grant to an empty warp: no pop, outputs 0.
  - ID arrival with out == 0: treated as a normal push, out saturates at 0.
- Latency: decoded instruction visible on `Ready_IB_ISS` the cycle after arrival. Pop visible on `Ready_IB_ISS`/`Req_IB_PC` the cycle after grant.

Optional Feature:
- IB_ERRCHK_EN defined: `Err_IB` port exists and is set sticky (cleared only by rst_n) on any of:
  - push to a full FIFO
  - grant to an empty warp
  - ID arrival for a warp with out == 0
  - more than one bit set in any one-hot input
- IB_ERRCHK_EN undefined: the port and its logic are absent; violations silently follow the ignore rules above.

Test Plan:
- Reset, idle 3 cycles → `Req_IB_PC`=8'hFF, `Ready_IB_ISS`=0, outputs 0.
- Warp 2: Valid_IF ×4 on consecutive cycles, no decode → `Req_IB_PC[2]`=0 after the 4th accept. Then 4 ID0 arrivals → `Ready_IB_ISS[2]`=1, occ=4, Req stays 0 until the first grant.
- Warp 5: ID0 and ID1 both valid same cycle with insts 0xA, 0xB → two grants pop 0xA then 0xB.
- Warp 1: occ=2, out=2, assert Flush → next cycle `Ready_IB_ISS[1]`=0, Req[1]=0. The next 2 arrivals are discarded, then Req[1]=1 and a new arrival becomes the head.
- Warp 3: full FIFO with push and grant same cycle → no loss, occ stays 4, FIFO order preserved across wrap-around.
- IB_ERRCHK_EN: grant to an empty warp 7 → `Err_IB`=1 next cycle, held until rst_n.
